wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 (ALU result) and requester 1 (load data from memory).
- Registers the winning request onto the write port.
- Drives the select line of the 5-bit destination-register 2:1 mux (0 = requester 0, 1 = requester 1).
- Sits between the execute/memory stages and the register file. Default priority goes to loads. A wait counter guarantees ALU forward progress.

Parameters:
- DATA_W, 32, writeback data width.
- MAX_WAIT, 3, consecutive denied cycles of requester 0 before it is forced to win; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- reqValid0  input  1  requester 0 has a write pending.
- reqReg0  input  5  requester 0 destination register.
- reqData0  input  DATA_W  requester 0 data.
- reqReady0  output  1  requester 0 accepted this cycle (combinational).
- reqValid1  input  1  requester 1 has a write pending.
- reqReg1  input  5  requester 1 destination register.
- reqData1  input  DATA_W  requester 1 data.
- reqReady1  output  1  requester 1 accepted this cycle (combinational).
- wbEnable  output  1  register-file write enable (registered).
- wbSelect  output  1  destination-mux select, 1 = requester 1 (registered).
- wbReg  output  5  write address (registered).
- wbData  output  DATA_W  write data (registered).
- waitCount  output  4  current starvation counter, for debug.

Behaviour:
- Reset (resetN low, asynchronous):
  - wbEnable=0, wbSelect=0, wbReg=0, wbData=0, waitCount=0, state=PRIO1.
  - reqReady0/1 = 0 while resetN is low.
- Handshake: a transfer occurs when reqValidN && reqReadyN at a clk rising edge. Ready depends only on both valids and the state, never on itself.
- At most one ready is high per cycle. A requester that is not granted must hold valid, reg and data stable.
- States:
  - PRIO1: requester 1 wins ties.
  - FORCE0: requester 0 wins ties.
- Grant rules:
  - Only one valid: that requester is granted, in either state.
  - Both valid in PRIO1: grant 1. waitCount increments (saturating at 15).
  - Both valid in FORCE0: grant 0.
  - Neither valid: no grant. Outputs update as for a cycle with no transfer.
- Counter and state:
  - In PRIO1, on the edge where waitCount+1 == MAX_WAIT during a denial of requester 0, the state moves to FORCE0.
  - Any cycle where requester 0 is granted: waitCount clears to 0 and the state returns to PRIO1.
  - Requester 0 not valid: waitCount clears to 0.
- Output stage, on each edge:
  - wbEnable <= transfer occurred && granted reqReg != 0.
  - wbSelect <= granted index. When there is no transfer, wbSelect holds its previous value.
  - wbReg and wbData load the granted request. When there is no transfer they hold their previous values.
- Latency: one cycle, from the accepting edge to wbEnable high at the register file.
- Writes to register 0 are accepted (ready=1) but dropped (wbEnable=0), so the requester never stalls.
- Same destination from both requesters in one cycle: resolved by the grant rules. The second write follows on a later cycle, so program order is the grant order.
- Reset mid-operation: in-flight registered write is discarded (wbEnable forced 0). Counter and state return to their reset values.

Optional Feature:
- WB_CONFLICT_STATS_EN.
- When defined:
  - Adds output conflictCount [15:0]. It increments on every cycle where both valids are high, saturating at 16'hFFFF, and clears on reset.
  - Adds output forceCount [7:0]. It increments on each entry into FORCE0, saturating, and clears on reset.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, then reqValid0=1, reqReg0=5'd8, reqData0=32'h1234 alone -> reqReady0=1 same cycle. Next cycle: wbEnable=1, wbSelect=0, wbReg=8, wbData=32'h1234.
- Both valid continuously (reg0=3, reg1=4), MAX_WAIT=3 -> grant sequence 1,1,1,0,1,1,1,0. waitCount reads 0,1,2,(force) then 0. wbSelect follows the grants one cycle later.
- reqValid1=1, reqReg1=0, data 32'hDEAD -> reqReady1=1. Next cycle wbEnable=0 and wbReg/wbData hold their prior values.
- Both valid with reqReg0=reqReg1=5'd9, data A/B -> first cycle writes B (wbSelect=1), next cycle writes A (wbSelect=0).
- Assert resetN low asynchronously between edges, one cycle after a grant -> wbEnable drops immediately, waitCount=0, state=PRIO1. After release, a contended request grants requester 1.
- With WB_CONFLICT_STATS_EN: 10 contended cycles at MAX_WAIT=3 -> conflictCount=10, forceCount=2. Without the macro the design compiles with no such ports.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Writeback bus between the two requesters (ALU = 0, load = 1) and the
//   register-file write port.
//   slave  : arbiter view (takes requests, drives readies and the write port)
//   master : environment view (drives requests, observes readies/write port)
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              reqValid0;
    logic [4:0]        reqReg0;
    logic [DATA_W-1:0] reqData0;
    logic              reqReady0;
    logic              reqValid1;
    logic [4:0]        reqReg1;
    logic [DATA_W-1:0] reqData1;
    logic              reqReady1;
    logic              wbEnable;
    logic              wbSelect;
    logic [4:0]        wbReg;
    logic [DATA_W-1:0] wbData;

    modport slave (
        input  reqValid0, reqReg0, reqData0,
        input  reqValid1, reqReg1, reqData1,
        output reqReady0, reqReady1,
        output wbEnable, wbSelect, wbReg, wbData
    );

    modport master (
        output reqValid0, reqReg0, reqData0,
        output reqValid1, reqReg1, reqData1,
        input  reqReady0, reqReady1,
        input  wbEnable, wbSelect, wbReg, wbData
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between requester 0 (ALU
//   result) and requester 1 (load data). Loads win ties by default; after
//   MAX_WAIT consecutive lost contests the ALU is owed the next tie.
//   The winning request is registered onto the write port (one cycle).
//
//   Ports:
//     clk        rising-edge clock
//     resetN     asynchronous active-low reset
//     bus        wb_port_arbiter_if.slave: requests in, readies and
//                registered write port (wbEnable/wbSelect/wbReg/wbData) out
//     waitCount  starvation counter of requester 0 (debug)
//   Optional (macro WB_CONFLICT_STATS_EN):
//     conflictCount  cycles with both requesters valid (saturating)
//     forceCount     entries into FORCE0 (saturating)
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  resetN,
    wb_port_arbiter_if.slave      bus,
`ifdef WB_CONFLICT_STATS_EN
    output logic [15:0]           conflictCount,
    output logic [7:0]            forceCount,
`endif
    output logic [3:0]            waitCount
);
    typedef enum logic {PRIO1 = 1'b0, FORCE0 = 1'b1} state_t;

    state_t            state, stateNext;
    logic [3:0]        waitNext;
    logic              grant0, grant1, contend, xfer, doWrite;
    logic [4:0]        grantReg;
    logic [DATA_W-1:0] grantData;

    // Grant, counter and next state. Ready depends only on the valids and
    // the state, so a requester can never deadlock waiting on its own ready.
    always_comb begin
        stateNext = state;
        waitNext  = waitCount;
        grant0    = 1'b0;
        grant1    = 1'b0;
        contend   = bus.reqValid0 && bus.reqValid1;

        if (contend) begin
            if (state == FORCE0) grant0 = 1'b1;
            else                 grant1 = 1'b1;
        end else if (bus.reqValid0) begin
            grant0 = 1'b1;
        end else if (bus.reqValid1) begin
            grant1 = 1'b1;
        end

        if (!bus.reqValid0) begin
            waitNext = 4'd0;
        end else if (grant0) begin
            waitNext  = 4'd0;
            stateNext = PRIO1;
        end else begin
            // Requester 0 lost a tie in PRIO1.
            if (waitCount != 4'hF) waitNext = waitCount + 4'd1;
            if (({1'b0, waitCount} + 5'd1) == 5'(MAX_WAIT)) stateNext = FORCE0;
        end
    end

    assign bus.reqReady0 = grant0 && resetN;
    assign bus.reqReady1 = grant1 && resetN;

    // Destination mux driven by the grant select.
    assign grantReg  = grant1 ? bus.reqReg1  : bus.reqReg0;
    assign grantData = grant1 ? bus.reqData1 : bus.reqData0;
    assign xfer      = grant0 || grant1;
    // Register-0 writes are accepted but dropped; the write port keeps the
    // address/data of the last real write.
    assign doWrite   = xfer && (grantReg != 5'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= PRIO1;
            waitCount <= 4'd0;
        end else begin
            state     <= stateNext;
            waitCount <= waitNext;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.wbEnable <= 1'b0;
            bus.wbSelect <= 1'b0;
            bus.wbReg    <= 5'd0;
            bus.wbData   <= '0;
        end else begin
            bus.wbEnable <= doWrite;
            if (xfer) bus.wbSelect <= grant1;
            if (doWrite) begin
                bus.wbReg  <= grantReg;
                bus.wbData <= grantData;
            end
        end
    end

`ifdef WB_CONFLICT_STATS_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            conflictCount <= 16'd0;
            forceCount    <= 8'd0;
        end else begin
            if (contend && conflictCount != 16'hFFFF)
                conflictCount <= conflictCount + 16'd1;
            if (state == PRIO1 && stateNext == FORCE0 && forceCount != 8'hFF)
                forceCount <= forceCount + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int DW = 32;
    localparam int MW = 3;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DW)) bus ();
    logic [3:0] waitCount;
`ifdef WB_CONFLICT_STATS_EN
    logic [15:0] conflictCount;
    logic [7:0]  forceCount;
`endif

    wb_port_arbiter #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus.slave),
`ifdef WB_CONFLICT_STATS_EN
        .conflictCount(conflictCount),
        .forceCount(forceCount),
`endif
        .waitCount(waitCount)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model: the ALU is "owed" a win after losing MW ties in a row;
    // an owed ALU wins the next tie. Loss streak resets whenever the ALU is
    // idle or wins.
    bit          mOwed;
    int          mStreak;
    bit          mEn, mSel;
    logic [4:0]  mReg;
    logic [31:0] mData;
    int          mConf, mForce;
    bit          lastG0, lastG1;
    logic        obsR0, obsR1;
    logic [3:0]  obsWc;

    task automatic modelReset();
        mOwed = 0; mStreak = 0; mEn = 0; mSel = 0; mReg = 0; mData = 0;
        mConf = 0; mForce = 0; lastG0 = 0; lastG1 = 0;
    endtask

    task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] r1, input logic [31:0] d1);
        bus.reqValid0 = v0; bus.reqReg0 = r0; bus.reqData0 = d0;
        bus.reqValid1 = v1; bus.reqReg1 = r1; bus.reqData1 = d1;
    endtask

    // One cycle: inputs already driven after a falling edge.
    task automatic step();
        bit g0, g1, v0, v1;
        logic [4:0] r;
        logic [31:0] d;
        int expWc;
        #1;
        v0 = bus.reqValid0; v1 = bus.reqValid1;
        g1 = v1 && (!v0 || !mOwed);
        g0 = v0 && !g1;
        expWc = (mStreak > 15) ? 15 : mStreak;
        obsR0 = bus.reqReady0; obsR1 = bus.reqReady1; obsWc = waitCount;
        chk("ready0", bus.reqReady0, g0);
        chk("ready1", bus.reqReady1, g1);
        chk("waitCount", waitCount, expWc);
        r = g1 ? bus.reqReg1 : bus.reqReg0;
        d = g1 ? bus.reqData1 : bus.reqData0;
        @(posedge clk);
        if (v0 && v1) mConf++;
        if (g0 || !v0) mStreak = 0;
        if (g0) mOwed = 0;
        if (v0 && !g0) begin
            mStreak++;
            if (mStreak == MW) begin mOwed = 1; mForce++; end
        end
        mEn = (g0 || g1) && (r != 0);
        if (g0 || g1) mSel = g1;
        if (mEn) begin mReg = r; mData = d; end
        #1;
        chk("wbEnable", bus.wbEnable, mEn);
        chk("wbSelect", bus.wbSelect, mSel);
        chk("wbReg", bus.wbReg, mReg);
        chk("wbData", bus.wbData, mData);
`ifdef WB_CONFLICT_STATS_EN
        chk("conflictCount", conflictCount, (mConf > 16'hFFFF) ? 16'hFFFF : mConf);
        chk("forceCount", forceCount, (mForce > 255) ? 255 : mForce);
`endif
        lastG0 = g0; lastG1 = g1;
        @(negedge clk);
    endtask

    int expG1[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int expWc[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        bit nv0, nv1;
        logic [4:0] nr0, nr1;
        logic [31:0] nd0, nd1;

        modelReset();
        drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        #1 resetN = 1'b0;
        #2;
        chk("rst_ready0", bus.reqReady0, 1'b0);
        chk("rst_ready1", bus.reqReady1, 1'b0);
        chk("rst_wbEnable", bus.wbEnable, 1'b0);
        chk("rst_wbSelect", bus.wbSelect, 1'b0);
        chk("rst_wbReg", bus.wbReg, 5'd0);
        chk("rst_wbData", bus.wbData, 32'd0);
        chk("rst_waitCount", waitCount, 4'd0);
        @(negedge clk);
        resetN = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // ALU alone.
        drive(1, 5'd8, 32'h1234, 0, 0, 0);
        step();
        chk("alone_ready0", obsR0, 1'b1);
        chk("alone_wbEnable", bus.wbEnable, 1'b1);
        chk("alone_wbSelect", bus.wbSelect, 1'b0);
        chk("alone_wbReg", bus.wbReg, 5'd8);
        chk("alone_wbData", bus.wbData, 32'h1234);

        // Load to register 0: accepted, dropped, port holds.
        drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
        step();
        chk("r0_ready1", obsR1, 1'b1);
        chk("r0_wbEnable", bus.wbEnable, 1'b0);
        chk("r0_wbReg", bus.wbReg, 5'd8);
        chk("r0_wbData", bus.wbData, 32'h1234);

        // Continuous contention.
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("seq_ready1_%0d", i), obsR1, expG1[i]);
            chk($sformatf("seq_wait_%0d", i), obsWc, expWc[i]);
            chk($sformatf("seq_sel_%0d", i), bus.wbSelect, expG1[i]);
        end

        // Same destination from both.
        drive(1, 5'd9, 32'hAAAA0000, 1, 5'd9, 32'hBBBB0000);
        step();
        chk("same_sel_B", bus.wbSelect, 1'b1);
        chk("same_data_B", bus.wbData, 32'hBBBB0000);
        drive(1, 5'd9, 32'hAAAA0000, 0, 0, 0);
        step();
        chk("same_sel_A", bus.wbSelect, 1'b0);
        chk("same_data_A", bus.wbData, 32'hAAAA0000);

        // Async reset mid-operation.
        drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
        step();
        step();
        #2 resetN = 1'b0;
        #1;
        modelReset();
        chk("mid_wbEnable", bus.wbEnable, 1'b0);
        chk("mid_waitCount", waitCount, 4'd0);
        chk("mid_ready0", bus.reqReady0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        step();
        chk("post_rst_ready1", obsR1, 1'b1);
        for (int i = 0; i < 9; i++) step();
`ifdef WB_CONFLICT_STATS_EN
        chk("stat_conflict10", conflictCount, 16'd10);
        chk("stat_force2", forceCount, 8'd2);
`endif

        // Randomized traffic; ungranted requesters hold their request.
        for (int i = 0; i < 400; i++) begin
            nv0 = bus.reqValid0; nr0 = bus.reqReg0; nd0 = bus.reqData0;
            nv1 = bus.reqValid1; nr1 = bus.reqReg1; nd1 = bus.reqData1;
            if (!nv0 || lastG0) begin
                nv0 = ($urandom_range(0, 3) != 0);
                nr0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                nd0 = $urandom;
            end
            if (!nv1 || lastG1) begin
                nv1 = ($urandom_range(0, 3) != 0);
                nr1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                nd1 = $urandom;
            end
            drive(nv0, nr0, nd0, nv1, nr1, nd1);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
